// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execute stage.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } exec_state_t;

  localparam int MAX_RUN = 32;

  // A run never covers more than the whole register file once.
  function automatic logic [5:0] clampCount(input logic [5:0] c);
    if (c > 6'(MAX_RUN)) return 6'(MAX_RUN);
    return c;
  endfunction

endpackage

// File: rtl/instr_exec_unit_if.sv
// Start command, register-file read port and result stream of the execute unit.
interface instr_exec_unit_if;
  import instr_register_pkg::*;

  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         busy;
  logic         done;
  logic         res_valid;
  logic         res_ready;
  result_t      res_data;
  address_t     res_addr;
  opcode_t      res_opcode;
  logic         res_err;

  // The side that issues runs, serves register reads and consumes results.
  modport master (
    output start, start_addr, count, instruction_word, res_ready,
    input  read_pointer, busy, done, res_valid, res_data, res_addr,
           res_opcode, res_err
  );

  // The execute unit itself.
  modport slave (
    input  start, start_addr, count, instruction_word, res_ready,
    output read_pointer, busy, done, res_valid, res_data, res_addr,
           res_opcode, res_err
  );

endinterface

// File: rtl/instr_exec_unit_alu.sv
// Purely combinational arithmetic for one instruction word.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  i_opcode,
  input  operand_t i_a,
  input  operand_t i_b,
  output result_t  o_result,
  output logic     o_err
);

  result_t w_a;
  result_t w_b;

  // Widen both operands with sign extension so every result fits in 64 bits.
  always_comb begin
    w_a = {{32{i_a[31]}}, i_a};
    w_b = {{32{i_b[31]}}, i_b};
  end

  // Evaluate the opcode; divide-by-zero and unknown encodings yield 0 with err set.
  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_opcode)
      ZERO:  o_result = '0;
      PASSA: o_result = w_a;
      PASSB: o_result = w_b;
      ADD:   o_result = w_a + w_b;
      SUB:   o_result = w_a - w_b;
      MULT:  o_result = w_a * w_b;
      DIV: begin
        if (w_b == '0) o_err = 1'b1;
        else           o_result = w_a / w_b;
      end
      MOD: begin
        if (w_b == '0) o_err = 1'b1;
        else           o_result = w_a % w_b;
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage: walks the register file from start_addr, runs each
// instruction through a fetch/execute pipeline and streams results out.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_exec_unit_if.slave   bus
);

  localparam address_t LAST_ENTRY = address_t'(NUM_ENTRIES - 1);

  exec_state_t  r_state;
  exec_state_t  w_nextState;

  address_t     r_ptr;
  logic [5:0]   r_remaining;

  logic         r_fValid;
  instruction_t r_fInstr;
  address_t     r_fAddr;

  logic         r_resValid;
  result_t      r_resData;
  address_t     r_resAddr;
  opcode_t      r_resOpcode;
  logic         r_resErr;
  logic         r_done;

  logic         w_stall;
  logic         w_startRun;
  logic         w_fetch;
  logic         w_drainExit;
  result_t      w_aluResult;
  logic         w_aluErr;

  assign w_stall     = r_resValid && !bus.res_ready;
  assign w_startRun  = (r_state == IDLE) && bus.start && (bus.count != 6'd0);
  assign w_fetch     = (r_state == RUN) && !w_stall;
  assign w_drainExit = (r_state == DRAIN) && !r_fValid && (!r_resValid || bus.res_ready);

  instr_alu u_alu (
    .i_opcode (r_fInstr.opc),
    .i_a      (r_fInstr.op_a),
    .i_b      (r_fInstr.op_b),
    .o_result (w_aluResult),
    .o_err    (w_aluErr)
  );

  // Run state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state: leave RUN once the last entry is fetched, leave DRAIN once the pipe is empty.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startRun) w_nextState = RUN;
      RUN:     if (w_fetch && (r_remaining == 6'd1)) w_nextState = DRAIN;
      DRAIN:   if (w_drainExit) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Read pointer and remaining-entry counter; both freeze while the output is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else if (w_startRun) begin
      r_ptr       <= bus.start_addr;
      r_remaining <= clampCount(bus.count);
    end else if (w_fetch) begin
      r_ptr       <= (r_ptr == LAST_ENTRY) ? '0 : r_ptr + 5'd1;
      r_remaining <= r_remaining - 6'd1;
    end
  end

  // Fetch stage: latch the word currently addressed together with its address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fValid <= 1'b0;
      r_fInstr <= '0;
      r_fAddr  <= '0;
    end else if (!w_stall) begin
      r_fValid <= w_fetch;
      if (w_fetch) begin
        r_fInstr <= bus.instruction_word;
        r_fAddr  <= r_ptr;
      end
    end
  end

  // Execute stage: register the ALU result; held untouched while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resValid  <= 1'b0;
      r_resData   <= '0;
      r_resAddr   <= '0;
      r_resOpcode <= ZERO;
      r_resErr    <= 1'b0;
    end else if (!w_stall) begin
      r_resValid <= r_fValid;
      if (r_fValid) begin
        r_resData   <= w_aluResult;
        r_resAddr   <= r_fAddr;
        r_resOpcode <= r_fInstr.opc;
        r_resErr    <= w_aluErr;
      end
    end
  end

  // Single-cycle completion pulse on the edge the run returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_done <= 1'b0;
    else          r_done <= w_drainExit;
  end

  assign bus.read_pointer = r_ptr;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;
  assign bus.res_valid    = r_resValid;
  assign bus.res_data     = r_resData;
  assign bus.res_addr     = r_resAddr;
  assign bus.res_opcode   = r_resOpcode;
  assign bus.res_err      = r_resErr;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit: a register-file model feeds the DUT,
// expected results are queued at issue time and checked by a monitor.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  typedef struct {
    logic [63:0] data;
    address_t    addr;
    logic [3:0]  opc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  instr_exec_unit_if bus();
  instruction_t regs [32];
  assign bus.instruction_word = regs[bus.read_pointer];

  instr_exec_unit #(.NUM_ENTRIES(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int doneCount = 0;
  int cycleCount = 0;
  exp_t sbQ[$];
  int acceptLog[$];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycleCount++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got nothing, expected an event", name);
  endtask

  // Behavioural model: signed 64-bit arithmetic, division by magnitudes.
  function automatic exp_t refModel(input instruction_t ins, input address_t addr);
    exp_t e;
    longint a, b, ua, ub, q;
    a = longint'(ins.op_a);
    b = longint'(ins.op_b);
    e.addr = addr;
    e.opc  = ins.opc;
    e.err  = 1'b0;
    e.data = '0;
    case (int'(ins.opc))
      0: e.data = '0;
      1: e.data = a;
      2: e.data = b;
      3: e.data = a + b;
      4: e.data = a - b;
      5: e.data = a * b;
      6, 7: begin
        if (b == 0) e.err = 1'b1;
        else begin
          ua = (a < 0) ? -a : a;
          ub = (b < 0) ? -b : b;
          q  = ua / ub;
          if ((a < 0) != (b < 0)) q = -q;
          e.data = (int'(ins.opc) == 6) ? q : a - q * b;
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  function automatic operand_t randOperand();
    case ($urandom_range(0, 6))
      0: return 32'sd0;
      1: return -32'sd1;
      2: return 32'sh7FFFFFFF;
      3: return 32'sh80000000;
      4: return operand_t'($urandom_range(0, 9));
      default: return operand_t'($urandom);
    endcase
  endfunction

  task automatic randomizeRegs();
    for (int i = 0; i < 32; i++) begin
      regs[i].opc  = opcode_t'(4'($urandom_range(0, 15)));
      regs[i].op_a = randOperand();
      regs[i].op_b = randOperand();
    end
  endtask

  task automatic setEntry(input int idx, input opcode_t opc, input operand_t a, input operand_t b);
    regs[idx].opc  = opc;
    regs[idx].op_a = a;
    regs[idx].op_b = b;
  endtask

  task automatic pushExp(input logic [63:0] data, input address_t addr, input opcode_t opc, input logic err);
    exp_t e;
    e.data = data;
    e.addr = addr;
    e.opc  = opc;
    e.err  = err;
    sbQ.push_back(e);
  endtask

  // Issue a run; the model's expectations are queued before start is raised.
  task automatic applyStimulus(input address_t addr, input logic [5:0] cnt, input bit useModel);
    int n;
    address_t a;
    n = (cnt > 6'd32) ? 32 : int'(cnt);
    if (useModel) begin
      for (int i = 0; i < n; i++) begin
        a = address_t'((int'(addr) + i) % 32);
        sbQ.push_back(refModel(regs[a], a));
      end
    end
    bus.start_addr = addr;
    bus.count      = cnt;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input bit randReady, input bit injectStart, output int busyCount);
    bit finished;
    finished  = 1'b0;
    busyCount = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (injectStart && i == 4) begin
        bus.start_addr = 5'd7;
        bus.count      = 6'd3;
        bus.start      = 1'b1;
      end else if (injectStart && i == 5) begin
        bus.start = 1'b0;
      end
      if (!bus.busy) begin
        finished = 1'b1;
        break;
      end
      busyCount++;
      if (randReady) bus.res_ready = ($urandom_range(0, 3) != 0);
    end
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    if (!finished) failNow("runTimeout");
    @(negedge clk);
    #1;
  endtask

  task automatic postRunChecks(input string tag, input int doneBefore, input int doneExpected);
    checkOutput({tag, "_donePulses"}, 64'(doneCount - doneBefore), 64'(doneExpected));
    checkOutput({tag, "_queueEmpty"}, 64'(sbQ.size()), 64'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_readPointer"}, 64'(bus.read_pointer), 64'd0);
    checkOutput({tag, "_busy"},        64'(bus.busy), 64'd0);
    checkOutput({tag, "_done"},        64'(bus.done), 64'd0);
    checkOutput({tag, "_resValid"},    64'(bus.res_valid), 64'd0);
    checkOutput({tag, "_resData"},     bus.res_data, 64'd0);
    checkOutput({tag, "_resAddr"},     64'(bus.res_addr), 64'd0);
    checkOutput({tag, "_resOpcode"},   64'(bus.res_opcode), 64'(ZERO));
    checkOutput({tag, "_resErr"},      64'(bus.res_err), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted result and watches stalls and done.
  initial begin
    logic        prevStall;
    logic        prevDone;
    logic [63:0] prevData;
    address_t    prevAddr;
    address_t    prevPtr;
    logic [3:0]  prevOpc;
    exp_t        e;
    prevStall = 1'b0;
    prevDone  = 1'b0;
    prevData  = '0;
    prevAddr  = '0;
    prevPtr   = '0;
    prevOpc   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevStall = 1'b0;
        prevDone  = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stallValid", 64'(bus.res_valid), 64'd1);
          checkOutput("stallData", bus.res_data, prevData);
          checkOutput("stallAddr", 64'(bus.res_addr), 64'(prevAddr));
          checkOutput("stallOpcode", 64'(bus.res_opcode), 64'(prevOpc));
          checkOutput("stallPointer", 64'(bus.read_pointer), 64'(prevPtr));
        end
        if (bus.done) begin
          doneCount++;
          checkOutput("doneWidth", 64'(prevDone), 64'd0);
        end
        if (bus.res_valid && bus.res_ready) begin
          if (sbQ.size() == 0) begin
            failNow("unexpectedResult");
          end else begin
            e = sbQ.pop_front();
            checkOutput("resData", bus.res_data, e.data);
            checkOutput("resAddr", 64'(bus.res_addr), 64'(e.addr));
            checkOutput("resOpcode", 64'(bus.res_opcode), 64'(e.opc));
            checkOutput("resErr", 64'(bus.res_err), 64'(e.err));
          end
          acceptLog.push_back(cycleCount);
        end
        prevStall = bus.res_valid && !bus.res_ready;
        prevDone  = bus.done;
        prevData  = bus.res_data;
        prevAddr  = bus.res_addr;
        prevOpc   = bus.res_opcode;
        prevPtr   = bus.read_pointer;
      end
    end
  end

  initial begin
    int bc;
    int doneBefore;
    int wrapSeq [3];
    address_t ra;
    wrapSeq = '{31, 0, 1};
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.count      = '0;
    bus.res_ready  = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    #3;
    checkReset("reset");
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    #1;

    // Basic arithmetic, latency and back-to-back output.
    setEntry(0, ADD, 5, 3);
    setEntry(1, SUB, 2, 9);
    setEntry(2, MULT, -4, 7);
    setEntry(3, DIV, 7, -2);
    pushExp(64'sd8, 5'd0, ADD, 1'b0);
    pushExp(-64'sd7, 5'd1, SUB, 1'b0);
    pushExp(-64'sd28, 5'd2, MULT, 1'b0);
    pushExp(-64'sd3, 5'd3, DIV, 1'b0);
    acceptLog.delete();
    doneBefore = doneCount;
    applyStimulus(5'd0, 6'd4, 1'b0);
    checkOutput("busyRise", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    checkOutput("latencyEdge1", 64'(bus.res_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("latencyEdge2", 64'(bus.res_valid), 64'd1);
    waitIdle(100, 1'b0, 1'b0, bc);
    checkOutput("busyCyclesRun4", 64'(3 + bc), 64'd6);
    checkOutput("acceptCountRun4", 64'(acceptLog.size()), 64'd4);
    if (acceptLog.size() == 4)
      checkOutput("consecutiveRun4", 64'(acceptLog[3] - acceptLog[0]), 64'd3);
    postRunChecks("arith", doneBefore, 1);

    // Corner arithmetic: signed modulo, divide by zero, wide multiply, min/-1.
    setEntry(0, MOD, -7, 3);
    setEntry(1, DIV, 5, 0);
    setEntry(2, MULT, 32'sh7FFFFFFF, 2);
    setEntry(3, DIV, 32'sh80000000, -1);
    pushExp(-64'sd1, 5'd0, MOD, 1'b0);
    pushExp(64'd0, 5'd1, DIV, 1'b1);
    pushExp(64'h00000000_FFFFFFFE, 5'd2, MULT, 1'b0);
    pushExp(64'h00000000_80000000, 5'd3, DIV, 1'b0);
    doneBefore = doneCount;
    applyStimulus(5'd0, 6'd4, 1'b0);
    waitIdle(100, 1'b0, 1'b0, bc);
    postRunChecks("corner", doneBefore, 1);

    // Pointer wrap from 30 through 1.
    randomizeRegs();
    doneBefore = doneCount;
    applyStimulus(5'd30, 6'd4, 1'b1);
    checkOutput("wrapPtr0", 64'(bus.read_pointer), 64'd30);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("wrapPtr", 64'(bus.read_pointer), 64'(wrapSeq[i]));
    end
    waitIdle(100, 1'b0, 1'b0, bc);
    postRunChecks("wrap", doneBefore, 1);

    // Consumer stalls for three cycles once the second result is taken.
    randomizeRegs();
    acceptLog.delete();
    doneBefore = doneCount;
    applyStimulus(5'd10, 6'd4, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    bus.res_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.res_ready = 1'b1;
    waitIdle(100, 1'b0, 1'b0, bc);
    checkOutput("stallAcceptCount", 64'(acceptLog.size()), 64'd4);
    postRunChecks("stall", doneBefore, 1);

    // count 0 does nothing.
    doneBefore = doneCount;
    applyStimulus(5'd5, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("countZeroBusy", 64'(bus.busy), 64'd0);
    end
    @(negedge clk); #1;
    checkOutput("countZeroValid", 64'(bus.res_valid), 64'd0);
    postRunChecks("countZero", doneBefore, 0);

    // count 40 clamps to 32; a start during the run is ignored.
    randomizeRegs();
    acceptLog.delete();
    doneBefore = doneCount;
    ra = address_t'($urandom_range(0, 31));
    applyStimulus(ra, 6'd40, 1'b1);
    waitIdle(200, 1'b0, 1'b1, bc);
    checkOutput("busyCyclesRun32", 64'(1 + bc), 64'd34);
    checkOutput("acceptCountRun32", 64'(acceptLog.size()), 64'd32);
    postRunChecks("clamp", doneBefore, 1);

    // Randomized runs with a randomly throttled consumer.
    for (int r = 0; r < 6; r++) begin
      randomizeRegs();
      doneBefore = doneCount;
      applyStimulus(address_t'($urandom_range(0, 31)), 6'($urandom_range(1, 40)), 1'b1);
      waitIdle(400, 1'b1, 1'b0, bc);
      postRunChecks("random", doneBefore, 1);
    end

    // Asynchronous reset in the middle of a run, then a fresh run.
    randomizeRegs();
    doneBefore = doneCount;
    applyStimulus(5'd3, 6'd20, 1'b1);
    repeat (6) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    checkReset("midReset");
    sbQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("midResetNoDone", 64'(doneCount - doneBefore), 64'd0);
    randomizeRegs();
    doneBefore = doneCount;
    applyStimulus(5'd12, 6'd7, 1'b1);
    waitIdle(100, 1'b0, 1'b0, bc);
    postRunChecks("afterReset", doneBefore, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
Downstream consumer of instr_register. On a start command it walks read_pointer across a run of register entries and executes each instruction_word (opc, op_a, op_b). Each result is streamed out through a valid/ready handshake with throughput of one per cycle. It is the execute stage that turns stored instructions into results for the checker/scoreboard side.

Parameters:
NUM_ENTRIES, 32, depth of instr_register; must equal 2**$bits(address_t).

Ports:
clk  input  1  single clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
start  input  1  pulse; begins a run when sampled high in IDLE
start_addr  input  address_t (5)  first entry of the run
count  input  6  entries to execute; 0 is ignored; values >32 clamp to 32
read_pointer  output  address_t (5)  to instr_register; registered
instruction_word  input  instruction_t  from instr_register; combinational read of read_pointer
busy  output  1  run in progress
done  output  1  one-cycle pulse after last result accepted
res_valid  output  1  result available
res_ready  input  1  consumer accepts when res_valid && res_ready
res_data  output  result_t (64, signed)  computed result
res_addr  output  address_t  entry the result came from
res_opcode  output  opcode_t  opcode executed
res_err  output  1  DIV/MOD by zero or undefined opcode

Behaviour:
- Reset (async, immediate): state IDLE; read_pointer 0, busy 0, done 0, res_valid 0, res_data 0, res_addr 0, res_opcode ZERO, res_err 0; both pipeline stages empty.
- FSM states:
  - IDLE: on start && count!=0, load ptr<=start_addr and remaining<=min(count,32), then go to RUN. busy rises on the same edge.
  - RUN: read_pointer=ptr.
  - DRAIN: entered once remaining reaches 0.
  - DRAIN exits to IDLE when the F stage is empty and the E stage is empty or accepted. done pulses high for exactly 1 cycle on that edge; busy falls on that edge.
- stall = res_valid && !res_ready. While stalled, ptr, remaining, the F stage and the E stage all hold.
- F stage (fetch): on each non-stalled edge in RUN, capture {instruction_word, ptr} and set F-valid.
  - ptr<=ptr+1, wrapping 31->0.
  - remaining<=remaining-1; when it becomes 0, go to DRAIN.
- E stage (execute): on a non-stalled edge, capture the F stage result into the output registers. res_valid<=F-valid.
- Latency: start is sampled at edge t0. The first res_valid is high after edge t2. Later results follow on consecutive cycles when res_ready=1.
- Handshake: while res_valid && !res_ready, res_data, res_addr, res_opcode and res_err are stable. res_valid never drops without acceptance, except on reset.
- Arithmetic: operands are sign-extended to 64 bits.
  - ZERO -> 0; PASSA -> a; PASSB -> b; ADD -> a+b; SUB -> a-b; MULT -> a*b (full 64-bit).
  - DIV -> a/b, truncating toward zero.
  - MOD -> a%b, with the sign of the dividend.
  - b==0 on DIV/MOD -> res_data 0, res_err 1.
  - Undefined opcode encoding -> res_data 0, res_err 1.
  - -2^31 / -1 = +2^31, with no error.
- Boundaries:
  - start while busy is ignored.
  - start with count 0 is ignored: no busy, no done.
  - Wrap-around is handled by the ptr rule above.
  - Register writes during a run are not blocked; each entry's value is taken at its fetch edge.
  - reset_n low mid-run aborts the run with no done pulse.

Decomposition:
- Add to instr_register_pkg:
  - result_t (signed 64-bit)
  - exec_state_t enum {IDLE, RUN, DRAIN}
  - MAX_RUN constant = 32
- Reuse the existing opcode_t, operand_t, address_t and instruction_t.
- One combinational sub-module, instr_alu: inputs opcode_t, operand_t a, operand_t b; outputs result_t and err. The exec unit owns the FSM, pointers, pipeline and handshake.

Test Plan:
- Entries 0-3 = ADD 5,3 / SUB 2,9 / MULT -4,7 / DIV 7,-2; start_addr 0, count 4, res_ready=1 -> res_data 8, -7, -28, -3 on 4 consecutive cycles. First result is valid 2 edges after start. done pulses once; res_addr 0..3.
- Entries: MOD -7,3 / DIV 5,0 / MULT 32'h7FFFFFFF,2 / DIV 32'h80000000,-1 -> -1 err0; 0 err1; 64'h00000000_FFFFFFFE; 64'h00000000_80000000 err0.
- start_addr 30, count 4 -> read_pointer sequence 30, 31, 0, 1; res_addr 30, 31, 0, 1; 4 results total.
- res_ready low for 3 cycles after the 2nd result -> outputs and read_pointer held stable. Exactly 4 results, no duplicates or losses, in order.
- start during busy is ignored; count 0 gives busy=0 and no done; count 40 gives exactly 32 results and busy for the full run.
- reset_n driven low asynchronously mid-run -> all outputs at reset values before the next posedge, no done. A new start afterwards runs correctly.
